// File: rtl/alu_arbiter_pkg.sv
// Shared encodings for the two-port ALU arbiter: op codes, FSM states, payload structs.
// Pure declarations; no latency or backpressure of its own.
package alu_arbiter_pkg;

    localparam int NUM_PORTS = 2;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0010,
        OP_SLT = 4'b1010,
        OP_AND = 4'b0100,
        OP_OR  = 4'b0101,
        OP_XOR = 4'b0110,
        OP_NOR = 4'b0111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_e;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } alu_req_t;

    typedef struct packed {
        logic [31:0] result;
        logic        c;
        logic        z;
        logic        err;
    } alu_rsp_t;

endpackage

// File: rtl/alu_arbiter_mips_alu.sv
// Purely combinational 32-bit MIPS-style ALU; zero latency, no flow control.
// Illegal op codes yield result 0, C 0, Z 1 with err raised.
module alu_arbiter_mips_alu
    import alu_arbiter_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output alu_rsp_t    o_rsp
);

    logic        w_sub;
    logic [31:0] w_b_eff;
    logic [32:0] w_sum;
    logic        w_lt;
    logic [31:0] w_res;
    logic        w_c;
    logic        w_err;

    // sub and slt share the adder as a + ~b + 1, so C is the no-borrow flag
    assign w_sub   = (i_op == OP_SUB) || (i_op == OP_SLT);
    assign w_b_eff = w_sub ? ~i_b : i_b;
    assign w_sum   = {1'b0, i_a} + {1'b0, w_b_eff} + {32'd0, w_sub};
    assign w_lt    = (i_a[31] != i_b[31]) ? i_a[31] : w_sum[31];

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_err = 1'b0;
        case (alu_op_e'(i_op))
            OP_ADD,
            OP_SUB: begin
                w_res = w_sum[31:0];
                w_c   = w_sum[32];
            end
            OP_SLT: begin
                w_res = {31'd0, w_lt};
                w_c   = w_sum[32];
            end
            OP_AND:  w_res = i_a & i_b;
            OP_OR:   w_res = i_a | i_b;
            OP_XOR:  w_res = i_a ^ i_b;
            OP_NOR:  w_res = ~(i_a | i_b);
            default: w_err = 1'b1;
        endcase
    end

    assign o_rsp.result = w_res;
    assign o_rsp.c      = w_c;
    assign o_rsp.z      = (w_res == 32'd0);
    assign o_rsp.err    = w_err;

endmodule

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of one registered ALU: IDLE accepts, EXEC computes, RESP holds.
// Response visible two cycles after acceptance; RESP holds until the granted port's rsp_ready.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int FAIR = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_PORTS-1:0]   req_valid,
    output logic [NUM_PORTS-1:0]   req_ready,
    input  logic [4*NUM_PORTS-1:0] req_op,
    input  logic [32*NUM_PORTS-1:0] req_a,
    input  logic [32*NUM_PORTS-1:0] req_b,
    output logic [NUM_PORTS-1:0]   rsp_valid,
    input  logic [NUM_PORTS-1:0]   rsp_ready,
    output logic [31:0]            rsp_result,
    output logic                   rsp_c,
    output logic                   rsp_z,
    output logic                   rsp_err
);

    state_e   r_state;
    state_e   w_next_state;
    logic     r_port;
    logic     r_last;
    alu_req_t r_req;
    alu_rsp_t r_rsp;
    alu_rsp_t w_alu_rsp;

    logic     w_grant_port;
    logic     w_accept;
    logic     w_rsp_hs;

    always_comb begin
        w_grant_port = req_valid[1];
        if (req_valid == 2'b11) begin
            w_grant_port = (FAIR != 0) ? ~r_last : 1'b0;
        end
    end

    // reset gates acceptance so nothing is granted in a reset cycle
    assign w_accept = (r_state == ST_IDLE) && (|req_valid) && !reset;
    assign w_rsp_hs = (r_state == ST_RESP) && rsp_ready[r_port];

    assign req_ready[0] = w_accept && !w_grant_port;
    assign req_ready[1] = w_accept &&  w_grant_port;

    assign rsp_valid[0] = (r_state == ST_RESP) && !r_port;
    assign rsp_valid[1] = (r_state == ST_RESP) &&  r_port;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next_state = ST_EXEC;
            ST_EXEC: w_next_state = ST_RESP;
            ST_RESP: if (w_rsp_hs) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_port <= 1'b0;
            r_last <= 1'b1;
            r_req  <= '0;
            r_rsp  <= '0;
        end else begin
            if (w_accept) begin
                r_port   <= w_grant_port;
                r_req.op <= w_grant_port ? req_op[7:4]  : req_op[3:0];
                r_req.a  <= w_grant_port ? req_a[63:32] : req_a[31:0];
                r_req.b  <= w_grant_port ? req_b[63:32] : req_b[31:0];
            end
            if (r_state == ST_EXEC) begin
                r_rsp <= w_alu_rsp;
            end
            if (w_rsp_hs) begin
                r_last <= r_port;
            end
        end
    end

    alu_arbiter_mips_alu MIPS_ALU (
        .i_op  (r_req.op),
        .i_a   (r_req.a),
        .i_b   (r_req.b),
        .o_rsp (w_alu_rsp)
    );

    assign rsp_result = r_rsp.result;
    assign rsp_c      = r_rsp.c;
    assign rsp_z      = r_rsp.z;
    assign rsp_err    = r_rsp.err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter against an arithmetic reference model.
// A second FAIR=0 instance shares the inputs and is checked in the continuous-request phase.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  rsp_ready;
    logic [7:0]  req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;

    logic [1:0]  req_ready, rsp_valid;
    logic [31:0] rsp_result;
    logic        rsp_c, rsp_z, rsp_err;

    logic [1:0]  f0_req_ready, f0_rsp_valid;
    logic [31:0] f0_rsp_result;
    logic        f0_rsp_c, f0_rsp_z, f0_rsp_err;

    int n_tests = 0;
    int n_fail  = 0;
    int last_served;

    always #5 clk = ~clk;

    alu_arbiter #(.FAIR(1)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_c(rsp_c), .rsp_z(rsp_z), .rsp_err(rsp_err)
    );

    alu_arbiter #(.FAIR(0)) u_dut_fixed (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(f0_req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(f0_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(f0_rsp_result), .rsp_c(f0_rsp_c), .rsp_z(f0_rsp_z), .rsp_err(f0_rsp_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: {err, z, c, result[31:0]}
    function automatic logic [34:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [32:0] wide;
        logic [31:0] r;
        logic        c, err;
        r = 0; c = 0; err = 0;
        case (op)
            4'b0000: begin wide = {1'b0, a} + {1'b0, b}; r = wide[31:0]; c = wide[32]; end
            4'b0010: begin r = a - b; c = (a >= b); end
            4'b1010: begin r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; c = (a >= b); end
            4'b0100: r = a & b;
            4'b0101: r = a | b;
            4'b0110: r = a ^ b;
            4'b0111: r = ~(a | b);
            default: err = 1;
        endcase
        return {err, (r == 0), c, r};
    endfunction

    function automatic logic [1:0] onehot(input int p);
        return (p == 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic set_port(input int p, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b);
        req_op[4*p +: 4] = op;
        req_a[32*p +: 32] = a;
        req_b[32*p +: 32] = b;
    endtask

    task automatic check_rsp(input string tag, input logic [34:0] exp);
        check({tag, "_result"}, rsp_result, exp[31:0]);
        check({tag, "_c"}, rsp_c, exp[32]);
        check({tag, "_z"}, rsp_z, exp[33]);
        check({tag, "_err"}, rsp_err, exp[34]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 2'b00;
        #1 check("rst_prio_ready", req_ready, 2'b00);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        req_valid = 2'b00;
        last_served = 1;
    endtask

    // One FAIR=1 transaction; both=1 makes the two ports contend.
    task automatic do_op(input bit both, input int port, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [3:0]  mop[2];
        logic [31:0] ma[2], mb[2];
        logic [34:0] exp;
        int win, oth;
        @(negedge clk);
        mop[port] = op; ma[port] = a; mb[port] = b;
        mop[1-port] = 4'($urandom); ma[1-port] = $urandom; mb[1-port] = $urandom;
        for (int p = 0; p < 2; p++) set_port(p, mop[p], ma[p], mb[p]);
        req_valid = both ? 2'b11 : onehot(port);
        rsp_ready = 2'b00;
        win = both ? (1 - last_served) : port;
        oth = 1 - win;
        exp = ref_alu(mop[win], ma[win], mb[win]);
        #1 check("grant", req_ready, onehot(win));
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        req_op = 8'($urandom); req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom};
        #1 check("exec_rsp_valid", rsp_valid, 2'b00);
        check("exec_req_ready", req_ready, 2'b00);
        @(posedge clk);
        @(negedge clk);
        check("rsp_valid", rsp_valid, onehot(win));
        check_rsp("rsp", exp);
        for (int h = 0; h < hold; h++) begin
            req_valid = onehot(oth);
            rsp_ready = onehot(oth);
            req_a = {$urandom, $urandom};
            #1 check("hold_req_ready", req_ready, 2'b00);
            @(posedge clk);
            @(negedge clk);
            check("hold_rsp_valid", rsp_valid, onehot(win));
            check("hold_result", rsp_result, exp[31:0]);
        end
        req_valid = 2'b00;
        rsp_ready = onehot(win);
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 2'b00;
        check("done_rsp_valid", rsp_valid, 2'b00);
        last_served = win;
    endtask

    initial begin
        logic [3:0] legal_ops [7];
        logic [3:0] op;
        logic [31:0] a, b;
        logic [34:0] exp;
        int cnt, g_exp;
        legal_ops = '{4'b0000, 4'b0010, 4'b1010, 4'b0100, 4'b0101, 4'b0110, 4'b0111};
        reset = 1'b1;
        req_valid = 2'b00; rsp_ready = 2'b00;
        req_op = 0; req_a = 0; req_b = 0;
        repeat (2) @(posedge clk);
        do_reset();

        #1 check("rst_rsp_valid", rsp_valid, 2'b00);
        check("rst_req_ready", req_ready, 2'b00);
        check_rsp("rst", 35'd0);

        do_op(0, 0, 4'b0000, 32'd5, 32'd7, 0);
        do_op(0, 1, 4'b0010, 32'h1234, 32'h1234, 0);
        do_op(0, 1, 4'b1010, 32'hFFFF_FFFF, 32'd1, 0);
        do_op(0, 0, 4'b1111, 32'hDEAD_BEEF, 32'h1, 5);

        for (int i = 0; i < 40; i++) begin
            op = ($urandom_range(0, 4) == 0) ? 4'($urandom) : legal_ops[$urandom_range(0, 6)];
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            do_op(bit'($urandom_range(0, 1)), $urandom_range(0, 1), op, a, b,
                  $urandom_range(0, 3));
        end

        // Abort in EXEC: no response, pointer back to port 0 first.
        @(negedge clk);
        set_port(1, 4'b0000, 32'd1, 32'd2);
        req_valid = 2'b10;
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        last_served = 1;
        check("abort_rsp_valid", rsp_valid, 2'b00);
        check("abort_result", rsp_result, 32'd0);
        rsp_ready = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_rsp", rsp_valid, 2'b00);
        end
        rsp_ready = 2'b00;
        req_valid = 2'b11;
        #1 check("abort_idle_grant", req_ready, 2'b01);
        req_valid = 2'b00;

        // Continuous contention on both instances.
        do_reset();
        set_port(0, 4'b0000, 32'd5, 32'd7);
        set_port(1, 4'b0010, 32'h1234, 32'h1234);
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            cnt = 0;
            #1;
            while (req_ready == 2'b00 && cnt < 10) begin
                @(negedge clk);
                #1 cnt++;
            end
            if (cnt >= 10) check("grant_timeout", 1'b0, 1'b1);
            g_exp = 1 - last_served;
            check("rr_grant", req_ready, onehot(g_exp));
            check("fixed_grant", f0_req_ready, 2'b01);
            exp = ref_alu(req_op[4*g_exp +: 4], req_a[32*g_exp +: 32], req_b[32*g_exp +: 32]);
            @(posedge clk); @(negedge clk);
            @(posedge clk); @(negedge clk);
            check("rr_rsp_valid", rsp_valid, onehot(g_exp));
            check("fixed_rsp_valid", f0_rsp_valid, 2'b01);
            check_rsp("rr", exp);
            check("fixed_result", f0_rsp_result, 32'd12);
            last_served = g_exp;
            @(posedge clk); @(negedge clk);
        end
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter FAIR, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority to port 0.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  2  per-port request valid; bit i = port i.
REQ-005 req_ready  output  2  per-port request accept; at most one bit high per cycle.
REQ-006 req_op  input  8  per-port ALU op; bits [4i+3:4i] = port i.
REQ-007 req_a  input  64  per-port operand A; bits [32i+31:32i] = port i.
REQ-008 req_b  input  64  per-port operand B; bits [32i+31:32i] = port i.
REQ-009 rsp_valid  output  2  per-port response valid; at most one bit high per cycle.
REQ-010 rsp_ready  input  2  per-port response accept.
REQ-011 rsp_result  output  32  ALU result for the port with rsp_valid high.
REQ-012 rsp_c  output  1  adder carry-out for that response.
REQ-013 rsp_z  output  1  result-is-zero flag for that response.
REQ-014 rsp_err  output  1  high when the accepted op was not a legal encoding.

Function
REQ-015 The legal ops SHALL be add 0000, sub 0010, slt 1010, and 0100, or 0101, xor 0110 and nor 0111; every other 4-bit code is illegal.
REQ-016 The FSM SHALL have three states, IDLE, EXEC and RESP, and leave reset in IDLE.
REQ-017 In IDLE with any req_valid high, the block SHALL set req_ready combinationally for the winning port only, capture that port's op/A/B and its index, and go to EXEC.
REQ-018 Arbitration SHALL work as follows:
- FAIR=1: the port not served last wins when both ports request.
- FAIR=0: port 0 always wins.
- A lone requester always wins.
REQ-019 In EXEC the ALU SHALL evaluate the registered operands; result, C, Z and err SHALL be registered; the state SHALL go to RESP.
REQ-020 In RESP the block SHALL hold rsp_valid for the granted port, with the payload stable, until that port's rsp_ready is high.
- On that handshake edge: go to IDLE and record the served port.
- rsp_ready on the non-granted port SHALL be ignored.
REQ-021 Latency SHALL be two cycles: a request accepted at edge N gives rsp_valid high from edge N+2 onward; peak throughput is one operation per 3 cycles.
REQ-022 In EXEC and RESP, req_ready SHALL be 00; pending requests wait and are not dropped.
REQ-023 An illegal op SHALL still complete with result 0, C 0, Z 1 and rsp_err 1.
REQ-024 C SHALL come from the 32-bit adder for add, sub and slt, and SHALL be 0 for logic ops; Z SHALL be 1 exactly when result is 0.
REQ-025 The round-robin pointer SHALL update only on a response handshake, never on request acceptance.

Reset
REQ-026 Reset SHALL set state to IDLE, req_ready 00, rsp_valid 00, rsp_result 0, rsp_c 0, rsp_z 0, rsp_err 0, and the last-served pointer to 1 (port 0 wins first).
REQ-027 Reset asserted in EXEC or RESP SHALL abort the operation with no response issued; the aborted requester must re-request.
REQ-028 Reset SHALL take priority over every simultaneous request or response event.

Structure
REQ-029 A shared package SHALL hold the ALU op encodings, the FSM state enum and the port count constant (2).
REQ-030 The block SHALL contain exactly one sub-module instance, MIPS_ALU, fed only from the registered operand/op flops.
REQ-031 There SHALL be no combinational path from req_a, req_b or req_op to any rsp_* output.

Verification
REQ-032 Port 0 add: A=5, B=7 -> rsp_valid=01 two cycles after accept, result=12, C=0, Z=0, err=0.
REQ-033 Port 1 sub: A=B=0x1234 -> result=0, Z=1, C=1; slt A=0xFFFFFFFF, B=1 -> result=1.
REQ-034 Both ports valid continuously, FAIR=1 -> grant order 0,1,0,1 over four operations; with FAIR=0 -> 0,0,0,0.
REQ-035 Back-pressure: hold rsp_ready=00 for 5 cycles in RESP -> payload stable, req_ready=00 throughout, completion the cycle after rsp_ready rises.
REQ-036 Illegal op 1111 -> result=0, Z=1, C=0, err=1.
REQ-037 Reset asserted in EXEC -> next cycle state IDLE, rsp_valid=00, and no response for the aborted request.
